// File: rtl/hidden_cpu_feeder_pkg.sv
// Shared types and constants for the hidden CPU instruction feeder.
// Instruction words use the core's {opcode, addrA, addrB} field layout.
package hidden_cpu_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } feeder_state_t;

  localparam int OPC_W     = 2;
  localparam int REG_W     = 2;
  localparam int INSTR_W   = OPC_W + 2 * REG_W;
  localparam int DEPTH_DEF = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hidden_cpu_feeder_if.sv
// Load, playback and PC-redirect signals between the feeder and its neighbours.
// master drives program/control, slave is the feeder itself.
interface hidden_cpu_feeder_if
  import hidden_cpu_feeder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic               load_en;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               run;
  logic               pc_sync;
  logic [7:0]         pc_in;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               done;
  logic [ADDR_W:0]    prog_len;

  modport master (
    output load_en, load_valid, load_data, run, pc_sync, pc_in,
    input  load_ready, instr_out, instr_valid, done, prog_len
  );

  modport slave (
    input  load_en, load_valid, load_data, run, pc_sync, pc_in,
    output load_ready, instr_out, instr_valid, done, prog_len
  );
endinterface

// File: rtl/hidden_cpu_prog_mem.sv
// Program buffer: synchronous write, registered synchronous read.
// The array is never reset; only the read register is.
module hidden_cpu_prog_mem
  import hidden_cpu_feeder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);
  logic [INSTR_W-1:0] mem_r [DEPTH];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register; holds its value whenever no read is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end
endmodule

// File: rtl/hidden_cpu_feeder.sv
// Instruction-feed stage: loads a program over valid/ready, then replays it
// one word per clock with PC-driven redirects.
module hidden_cpu_feeder
  import hidden_cpu_feeder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst,
  hidden_cpu_feeder_if.slave bus
);
  // Wide enough for both the 8-bit PC and prog_len, so no PC bit is dropped
  localparam int              CMP_W   = max_int(ADDR_W + 1, 8);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  feeder_state_t      state_r, state_nxt_s;
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W:0]    prog_len_r;
  logic [ADDR_W:0]    fa_r;
  logic               first_r;
  logic               valid_r;
  logic               done_r;
  logic               load_ready_s;
  logic               wr_en_s;
  logic               rd_en_s;
  logic               clr_load_s;
  logic               start_run_s;
  logic               in_range_s;
  logic [CMP_W-1:0]   na_s;
  logic [INSTR_W-1:0] rd_data_s;

  assign load_ready_s = (state_r == LOAD) && (prog_len_r < DEPTH_L);
  assign in_range_s   = na_s < CMP_W'(prog_len_r);

  // Next fetch address: redirect, first word of a run, or increment
  always_comb begin
    na_s = '0;
    if (bus.pc_sync) begin
      na_s = CMP_W'(bus.pc_in);
    end else if (first_r) begin
      na_s = '0;
    end else begin
      na_s = CMP_W'(fa_r) + CMP_W'(1'b1);
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    clr_load_s  = 1'b0;
    start_run_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.load_en) begin
          state_nxt_s = LOAD;
          clr_load_s  = 1'b1;
        end else if (bus.run) begin
          state_nxt_s = RUN;
          start_run_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        wr_en_s = bus.load_valid && load_ready_s;
        if (bus.load_en) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!bus.run) begin
          state_nxt_s = IDLE;
        end else if (in_range_s) begin
          state_nxt_s = RUN;
          rd_en_s     = 1'b1;
        end else begin
          state_nxt_s = HALT;
        end
      end
      HALT: begin
        if (bus.run) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointers, fetch address and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      prog_len_r <= '0;
      fa_r       <= '0;
      first_r    <= 1'b0;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (clr_load_s) begin
        wr_ptr_r   <= '0;
        prog_len_r <= '0;
      end else if (wr_en_s) begin
        wr_ptr_r   <= wr_ptr_r + ADDR_W'(1'b1);
        prog_len_r <= prog_len_r + (ADDR_W + 1)'(1'b1);
      end
      if (start_run_s) begin
        fa_r    <= '0;
        first_r <= 1'b1;
      end else if (rd_en_s) begin
        fa_r    <= na_s[ADDR_W:0];
        first_r <= 1'b0;
      end
      valid_r <= rd_en_s;
      done_r  <= (state_nxt_s == HALT);
    end
  end

  hidden_cpu_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (bus.load_data),
    .rd_en   (rd_en_s),
    .rd_addr (na_s[ADDR_W-1:0]),
    .rd_data (rd_data_s)
  );

  assign bus.load_ready  = load_ready_s;
  assign bus.instr_out   = rd_data_s;
  assign bus.instr_valid = valid_r;
  assign bus.done        = done_r;
  assign bus.prog_len    = prog_len_r;
endmodule

// File: tb/tb_hidden_cpu_feeder.sv
// Randomized scoreboard bench for hidden_cpu_feeder: the driver predicts the
// replayed word stream from a simple array model, a monitor checks it.
module tb_hidden_cpu_feeder;
  import hidden_cpu_feeder_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    bit         is_end;
    logic [5:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hidden_cpu_feeder_if #(.DEPTH(DEPTH)) bus_if ();

  hidden_cpu_feeder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb_q[$];
  logic [5:0] m_mem[DEPTH];
  int         m_len = 0;
  logic       done_prev = 1'b0;
  exp_t       mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_end, input logic [5:0] word);
    exp_t it;
    it.is_end = is_end;
    it.word   = word;
    sb_q.push_back(it);
  endtask

  // Monitor: pops one expectation per presented word or per end-of-program
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.instr_valid && bus_if.done) begin
        n_vec++; n_err++;
        $display("FAIL valid_and_done: instr_valid and done both high");
      end
      if (bus_if.instr_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_word: got %0h, expected nothing", bus_if.instr_out);
        end else begin
          mon_e = sb_q.pop_front();
          check("item_is_word", 1, mon_e.is_end ? 0 : 1);
          check("instr_out", bus_if.instr_out, mon_e.word);
        end
      end
      if (bus_if.done && !done_prev) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done, expected nothing");
        end else begin
          mon_e = sb_q.pop_front();
          check("item_is_end", 1, mon_e.is_end ? 1 : 0);
        end
      end
    end
    done_prev = bus_if.done;
  end

  task automatic load(input logic [5:0] words[$]);
    bus_if.load_en = 1'b1;
    tick();
    m_len = 0;
    for (int i = 0; i < words.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus_if.load_valid = 1'b0;
        tick();
      end
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = words[i];
      if (i == words.size() - 1) bus_if.load_en = 1'b0;
      check("load_ready", bus_if.load_ready, (m_len < DEPTH) ? 1 : 0);
      if (m_len < DEPTH) begin
        m_mem[m_len] = words[i];
        m_len++;
      end
      tick();
    end
    bus_if.load_valid = 1'b0;
    if (words.size() == 0) begin
      bus_if.load_en = 1'b0;
      tick();
    end
    check("prog_len", bus_if.prog_len, m_len);
  endtask

  // Plays the program; address sequence 0,1,2.. unless a redirect is issued
  task automatic play(input int pct, input int dir_step, input int dir_pc);
    int addr;
    int na;
    int pc;
    bit first;
    bit stop;
    bit sync;
    bus_if.run = 1'b1;
    tick();
    first = 1'b1;
    stop  = 1'b0;
    addr  = 0;
    for (int s = 0; s < 40 && !stop; s++) begin
      sync = 1'b0;
      pc   = 0;
      if (s == dir_step) begin
        sync = 1'b1;
        pc   = dir_pc;
      end else if ($urandom_range(0, 99) < pct) begin
        sync = 1'b1;
        pc   = ($urandom_range(0, 9) == 0) ? 200 + $urandom_range(0, 55)
                                           : $urandom_range(0, m_len + 2);
      end
      na    = sync ? pc : (first ? 0 : addr + 1);
      first = 1'b0;
      if (na < m_len) begin
        push_exp(1'b0, m_mem[na]);
        addr = na;
      end else begin
        push_exp(1'b1, 6'h00);
        stop = 1'b1;
      end
      bus_if.pc_sync = sync;
      bus_if.pc_in   = 8'(pc);
      tick();
    end
    bus_if.pc_sync = 1'b0;
    bus_if.pc_in   = 8'h00;
    if (stop) begin
      tick();
      check("halt_done", bus_if.done, 1);
      check("halt_valid", bus_if.instr_valid, 0);
    end
    bus_if.run = 1'b0;
    tick();
    check("idle_done", bus_if.done, 0);
    check("idle_valid", bus_if.instr_valid, 0);
  endtask

  initial begin
    logic [5:0] w[$];
    bus_if.load_en    = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = 6'h00;
    bus_if.run        = 1'b0;
    bus_if.pc_sync    = 1'b0;
    bus_if.pc_in      = 8'h00;
    tick();
    tick();
    check("rst_load_ready", bus_if.load_ready, 0);
    check("rst_instr_valid", bus_if.instr_valid, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_instr_out", bus_if.instr_out, 0);
    check("rst_prog_len", bus_if.prog_len, 0);
    #2 rst = 1'b0;
    tick();

    // Load then play
    w = '{6'h01, 6'h12, 6'h23};
    load(w);
    play(0, -1, 0);

    // Full buffer: 18 offered, 16 kept
    w.delete();
    for (int i = 0; i < 18; i++) w.push_back(6'($urandom_range(0, 63)));
    load(w);
    play(0, -1, 0);

    // Redirect to word 2 after word 5
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back(6'(i));
    load(w);
    play(0, 6, 2);

    // Out-of-range redirect
    w.delete();
    for (int i = 0; i < 4; i++) w.push_back(6'($urandom_range(0, 63)));
    load(w);
    play(0, 1, 200);

    // load_en beats run; then an empty program halts at once
    bus_if.load_en = 1'b1;
    bus_if.run     = 1'b1;
    tick();
    check("prio_load_ready", bus_if.load_ready, 1);
    check("prio_valid", bus_if.instr_valid, 0);
    bus_if.load_en = 1'b0;
    bus_if.run     = 1'b0;
    tick();
    m_len = 0;
    check("empty_prog_len", bus_if.prog_len, 0);
    play(0, -1, 0);

    // Randomized programs with random redirects
    for (int it = 0; it < 8; it++) begin
      w.delete();
      for (int i = 0; i < $urandom_range(0, 18); i++) w.push_back(6'($urandom_range(0, 63)));
      load(w);
      play(25, -1, 0);
    end

    // Asynchronous reset during playback
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(6'($urandom_range(0, 63)));
    load(w);
    bus_if.run = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      push_exp(1'b0, m_mem[s]);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("arst_instr_valid", bus_if.instr_valid, 0);
    check("arst_done", bus_if.done, 0);
    check("arst_instr_out", bus_if.instr_out, 0);
    check("arst_prog_len", bus_if.prog_len, 0);
    check("arst_load_ready", bus_if.load_ready, 0);
    sb_q.delete();
    bus_if.run = 1'b0;
    m_len = 0;
    tick();
    #2 rst = 1'b0;
    tick();
    check("post_rst_prog_len", bus_if.prog_len, 0);
    check("post_rst_valid", bus_if.instr_valid, 0);

    tick();
    tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
